// File: rtl/vga_if.sv
// vga_if: video-memory read port, pixel/sync outputs and raster position of the scanout engine.
interface vga_if;
    logic [2:0]  border_color;
    logic [15:0] read_addr;
    logic [2:0]  read_data;
    logic [2:0]  rgb;
    logic        hsync;
    logic        vsync;
    logic [9:0]  hcount;
    logic [9:0]  vcount;
    logic        frame_start;
    modport master (
        input  border_color, read_data,
        output read_addr, rgb, hsync, vsync, hcount, vcount, frame_start
    );
    modport slave (
        output border_color, read_data,
        input  read_addr, rgb, hsync, vsync, hcount, vcount, frame_start
    );
endinterface

// File: rtl/vga_scanout.sv
// vga_scanout: 640x480@60 VGA timing at half clock rate with a 256x256 memory-backed window.
module vga_scanout #(
    parameter int WIN_X = 192,
    parameter int WIN_Y = 112
) (
    input  logic   clk_i,
    input  logic   rst_ni,
    vga_if.master  bus
);
    logic       phase_q, phase_d;
    logic [9:0] h_q, h_d, v_q, v_d;
    logic [2:0] rgb_q, rgb_d;
    logic       hs_q, hs_d, vs_q, vs_d, fs_q, fs_d;
    logic       h_end, v_end, visible, in_win;
    logic [7:0] col, row;
    always_comb begin
        h_end   = h_q == 10'd799;
        v_end   = v_q == 10'd524;
        visible = h_q < 10'd640 && v_q < 10'd480;
        // window bounds compared one bit wider so WIN+255 cannot wrap
        in_win  = {1'b0, h_q} >= 11'(WIN_X) && {1'b0, h_q} <= 11'(WIN_X + 255) &&
                  {1'b0, v_q} >= 11'(WIN_Y) && {1'b0, v_q} <= 11'(WIN_Y + 255);
        col     = 8'(h_q - 10'(WIN_X));
        row     = 8'(v_q - 10'(WIN_Y));
        phase_d = ~phase_q;
        h_d     = phase_q ? (h_end ? 10'd0 : h_q + 10'd1) : h_q;
        v_d     = (phase_q && h_end) ? (v_end ? 10'd0 : v_q + 10'd1) : v_q;
        rgb_d   = phase_q ? (!visible ? 3'b000 : in_win ? bus.read_data : bus.border_color) : rgb_q;
        hs_d    = phase_q ? !(h_q >= 10'd656 && h_q <= 10'd751) : hs_q;
        vs_d    = phase_q ? !(v_q >= 10'd490 && v_q <= 10'd491) : vs_q;
        fs_d    = phase_q && h_end && v_end;
    end
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            phase_q <= 1'b0;
            h_q     <= '0;
            v_q     <= '0;
            rgb_q   <= '0;
            hs_q    <= 1'b1;
            vs_q    <= 1'b1;
            fs_q    <= 1'b0;
        end else begin
            phase_q <= phase_d;
            h_q     <= h_d;
            v_q     <= v_d;
            rgb_q   <= rgb_d;
            hs_q    <= hs_d;
            vs_q    <= vs_d;
            fs_q    <= fs_d;
        end
    end
    assign bus.read_addr   = in_win ? {col, row} : 16'h0000;
    assign bus.rgb         = rgb_q;
    assign bus.hsync       = hs_q;
    assign bus.vsync       = vs_q;
    assign bus.hcount      = h_q;
    assign bus.vcount      = v_q;
    assign bus.frame_start = fs_q;
endmodule

// File: doc/vga_scanout.md
VGA_SCANOUT -- requirements
Module: vga_scanout

Interface
REQ-001 Parameter WIN_X, default 192: first visible column of the 256x256 video window.
REQ-002 Parameter WIN_Y, default 112: first visible row of the 256x256 video window.
REQ-003 Clock  input  1  50 MHz system clock; all state changes on its rising edge.
REQ-004 Reset  input  1  asynchronous, active-low; asserted (0) forces the reset state immediately, regardless of Clock.
REQ-005 iBorderColor  input  3  {R,G,B} shown in the visible area outside the window.
REQ-006 oReadAddress  output  16  video-memory read address {column[7:0], row[7:0]}.
REQ-007 iReadData  input  3  {R,G,B} returned by video memory one Clock after oReadAddress.
REQ-008 oVGA_RGB  output  3  registered {R,G,B} pixel to the DAC pins.
REQ-009 oHsync  output  1  registered horizontal sync, active-low.
REQ-010 oVsync  output  1  registered vertical sync, active-low.
REQ-011 oHcounter  output  10  current horizontal position, 0..799.
REQ-012 oVcounter  output  10  current vertical position, 0..524.
REQ-013 oFrameStart  output  1  one-Clock pulse when the position wraps to (0,0).

Function
REQ-014 An internal phase bit SHALL toggle every Clock; a pixel tick is a Clock edge with phase = 1 (25 MHz pixel rate, 2 Clocks per pixel).
REQ-015 On each pixel tick oHcounter SHALL increment; at 799 it SHALL wrap to 0 and oVcounter SHALL increment; at oVcounter = 524 with oHcounter = 799, both SHALL wrap to 0.
REQ-016 Counters SHALL hold on non-tick edges.
REQ-017 Horizontal timing: visible 0..639, front porch 640..655, sync 656..751, back porch 752..799.
REQ-018 Vertical timing: visible 0..479, front porch 480..489, sync 490..491, back porch 492..524.
REQ-019 In-window: WIN_X <= h <= WIN_X+255 AND WIN_Y <= v <= WIN_Y+255, using the current counters.
REQ-020 oReadAddress SHALL be combinational from the counters: {(h-WIN_X)[7:0], (v-WIN_Y)[7:0]} when in-window; otherwise 16'h0000.
REQ-021 oReadAddress SHALL be stable for both Clocks of a pixel period; iReadData SHALL be sampled only on the pixel-tick edge.
REQ-022 On each pixel tick the output registers SHALL load, for the position being left:
- iReadData when in-window;
- iBorderColor when visible but outside the window;
- 3'b000 when in blanking;
- oHsync = 0 while h is in 656..751, else 1;
- oVsync = 0 while v is in 490..491, else 1.
REQ-023 Latency: oVGA_RGB, oHsync and oVsync SHALL be mutually aligned and SHALL lag the counter position by exactly one pixel period (2 Clocks).
REQ-024 oFrameStart SHALL be 1 for exactly the single Clock after the tick that wraps the counters to (0,0); it SHALL be 0 otherwise.
REQ-025 Window coordinates SHALL use 10-bit arithmetic internally; only the low 8 bits form the address.
REQ-026 A window exceeding the visible area SHALL still use the REQ-019 test; blanking (REQ-022) SHALL take priority over in-window.
REQ-027 iBorderColor changes SHALL take effect at the next pixel tick; there is no other latching.

Reset
REQ-028 While Reset = 0, the block SHALL hold: phase 0, counters 0, oVGA_RGB 3'b000, oHsync 1, oVsync 1, oFrameStart 0.
REQ-029 After Reset deasserts, the first pixel tick SHALL occur on the second Clock edge.
REQ-030 Reset asserted mid-line or mid-frame SHALL abandon the frame; the next frame SHALL start from (0,0) with no partial sync pulse.

Verification
REQ-031 Scenario: reset release, free-run 2 frames -> oHsync low 96 ticks per 800; oVsync low 1600 ticks per 420000; oFrameStart pulses exactly once per 840000 Clocks.
REQ-032 Scenario: RAM model returns the low 3 bits of (column XOR row), iBorderColor = 3'b101 -> at h = 192, v = 112 the address is 16'h0000; at h = 447, v = 367 it is 16'hFFFF; RGB appears one pixel later; h = 191 shows 3'b101.
REQ-033 Scenario: RAM model drives 3'b111 constantly, iBorderColor = 3'b111 -> oVGA_RGB = 0 for every h >= 640 or v >= 480.
REQ-034 Scenario: oHcounter = 799, oVcounter = 524 tick -> both counters read 0, oFrameStart = 1 for one Clock, oVsync = 1.
REQ-035 Scenario: Reset pulsed low for 3 ns (asynchronous) at h = 700 -> outputs reach reset values before the next Clock edge; restart from (0,0).
REQ-036 Scenario: iBorderColor toggles on a non-tick Clock -> no output change until the following tick.
